txdata_hex: RTL and testbench

//  Downstream of the event counter: snapshots a 32-bit word (the count) on a

---
 rtl/txdata_hex.sv | 124 ++++++++++++
 tb/tb_txdata_hex.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/txdata_hex.sv
// Snapshots a 32-bit word on a strobe and streams it to a UART as ASCII hex + CR LF.
// Define TXDATA_PREFIX_EN to prepend "0x" to every line.
module txdata_hex #(
    parameter bit UPPER_HEX = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_uart_stb,
    output logic [7:0]  o_uart_data,
    input  logic        i_uart_busy
);

`ifdef TXDATA_PREFIX_EN
    localparam logic [3:0] DIG0 = 4'd2;
    localparam logic [3:0] LAST = 4'd11;
`else
    localparam logic [3:0] DIG0 = 4'd0;
    localparam logic [3:0] LAST = 4'd9;
`endif
    // Index of the CR byte; digits occupy DIG0 .. DIG_END-1
    localparam logic [3:0] DIG_END = DIG0 + 4'd8;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sreg_q, sreg_d;
    logic [3:0]  idx_q, idx_d;
    logic        stb_q, stb_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] shifted;
    logic        is_digit;
    logic        accept;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] base;
        base = UPPER_HEX ? 8'h41 : 8'h61;
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return base + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [7:0] line_byte(
        input logic [3:0]  idx,
        input logic [31:0] s
    );
        logic [7:0] b;
        b = 8'h0a;
`ifdef TXDATA_PREFIX_EN
        if (idx == 4'd0) b = 8'h30;
        else if (idx == 4'd1) b = 8'h78;
        else
`endif
        if (idx < DIG_END) b = hex_char(s[31:28]);
        else if (idx == DIG_END) b = 8'h0d;
        else b = 8'h0a;
        return b;
    endfunction

    assign accept = stb_q && !i_uart_busy;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        stb_d   = stb_q;
        data_d  = data_q;
`ifdef TXDATA_PREFIX_EN
        is_digit = (idx_q >= DIG0) && (idx_q < DIG_END);
`else
        is_digit = idx_q < DIG_END;
`endif
        // The nibble on show leaves the register only once it is accepted
        shifted = is_digit ? {sreg_q[27:0], 4'h0} : sreg_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_stb) begin
                    state_d = S_SEND;
                    sreg_d  = i_data;
                    idx_d   = 4'd0;
                    stb_d   = 1'b1;
                    data_d  = line_byte(4'd0, i_data);
                end
            end
            S_SEND: begin
                if (accept) begin
                    if (idx_q == LAST) begin
                        state_d = S_IDLE;
                        stb_d   = 1'b0;
                    end else begin
                        sreg_d = shifted;
                        idx_d  = idx_q + 4'd1;
                        data_d = line_byte(idx_q + 4'd1, shifted);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            sreg_q  <= 32'h0;
            idx_q   <= 4'd0;
            stb_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            stb_q   <= stb_d;
            data_q  <= data_d;
        end
    end

    assign o_busy      = (state_q == S_SEND);
    assign o_uart_stb  = stb_q;
    assign o_uart_data = data_q;

endmodule

// File: tb/tb_txdata_hex.sv
// Scoreboard bench for txdata_hex: lowercase and uppercase instances share stimulus.
// Expected lines are built from the word with plain arithmetic; a negedge monitor checks.
module tb_txdata_hex;

`ifdef TXDATA_PREFIX_EN
    localparam int LEN = 12;
`else
    localparam int LEN = 10;
`endif

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stb = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic        i_uart_busy = 1'b0;
    logic        busy_lo, stb_lo, busy_up, stb_up;
    logic [7:0]  data_lo, data_up;

    int checks = 0;
    int errors = 0;
    int bmode = 0;
    bit mon_en = 1'b0;
    logic [7:0] q[$];

    txdata_hex #(.UPPER_HEX(1'b0)) u_lo (
        .i_clk(clk), .i_reset(i_reset), .i_stb(i_stb), .i_data(i_data),
        .o_busy(busy_lo), .o_uart_stb(stb_lo), .o_uart_data(data_lo),
        .i_uart_busy(i_uart_busy)
    );

    txdata_hex #(.UPPER_HEX(1'b1)) u_up (
        .i_clk(clk), .i_reset(i_reset), .i_stb(i_stb), .i_data(i_data),
        .o_busy(busy_up), .o_uart_stb(stb_up), .o_uart_data(data_up),
        .i_uart_busy(i_uart_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_up(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h66) return c - 8'h20;
        return c;
    endfunction

    // Reference: text of one line for word d, lowercase digits
    task automatic push_line(input logic [31:0] d);
        int n;
`ifdef TXDATA_PREFIX_EN
        q.push_back(8'h30);
        q.push_back(8'h78);
`endif
        for (int i = 7; i >= 0; i--) begin
            n = int'((d >> (4 * i)) & 32'hF);
            if (n < 10) q.push_back(8'(48 + n));
            else q.push_back(8'(97 + n - 10));
        end
        q.push_back(8'h0d);
        q.push_back(8'h0a);
    endtask

    // UART busy pattern: 0 free, 1 toggling, 2 random, 3 stuck busy
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bmode)
                0: i_uart_busy = 1'b0;
                1: i_uart_busy = ~i_uart_busy;
                2: i_uart_busy = 1'($urandom_range(0, 1));
                default: i_uart_busy = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            exp_busy = (q.size() != 0);
            chk("busy_lo", 32'(busy_lo), 32'(exp_busy));
            chk("stb_lo", 32'(stb_lo), 32'(exp_busy));
            chk("busy_up", 32'(busy_up), 32'(exp_busy));
            chk("stb_up", 32'(stb_up), 32'(exp_busy));
            if (exp_busy) begin
                chk("byte_lo", 32'(data_lo), 32'(q[0]));
                chk("byte_up", 32'(data_up), 32'(to_up(q[0])));
                if (!i_uart_busy) void'(q.pop_front());
            end
        end
    end

    // Caller must be at posedge+1 with the DUT idle
    task automatic send(input logic [31:0] d);
        i_stb = 1'b1;
        i_data = d;
        @(posedge clk);
        #1;
        i_stb = 1'b0;
        i_data = $urandom;
        push_line(d);
    endtask

    // Returns at posedge+1 of the first idle cycle; noisy pulses ignored strobes
    task automatic wait_done(input bit noisy);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            if (q.size() == 0) break;
            n++;
            if (n > 3000) begin
                chk("line_timeout", 32'(q.size()), 32'd0);
                q.delete();
                break;
            end
            #1;
            i_stb = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            i_data = $urandom;
        end
        #1;
        i_stb = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        chk("rst_data_lo", 32'(data_lo), 32'h0);
        chk("rst_data_up", 32'(data_up), 32'h0);
        chk("rst_busy", 32'(busy_lo), 32'h0);
        chk("rst_stb", 32'(stb_lo), 32'h0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        bmode = 0;
        send(32'h0000_002A);
        wait_done(1'b0);

        bmode = 1;
        send(32'hDEAD_BEEF);
        wait_done(1'b0);

        bmode = 2;
        send(32'h1234_5678);
        wait_done(1'b1);

        // Reset after the third byte is accepted
        bmode = 2;
        send(32'hCAFE_F00D);
        begin
            int n;
            n = 0;
            forever begin
                @(posedge clk);
                if (q.size() <= LEN - 3) break;
                n++;
                if (n > 3000) begin
                    chk("rst_wait_timeout", 32'(q.size()), 32'(LEN - 3));
                    break;
                end
            end
        end
        #1;
        bmode = 3;
        i_uart_busy = 1'b1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        q.delete();
        bmode = 0;
        @(negedge clk);
        chk("abort_stb", 32'(stb_lo), 32'h0);
        chk("abort_busy", 32'(busy_up), 32'h0);
        @(posedge clk);
        #1;
        send(32'h0000_0001);
        wait_done(1'b0);

        // Back-to-back lines, including the all-F boundary word
        send(32'hFFFF_FFFF);
        wait_done(1'b0);
        send(32'h0000_0000);
        wait_done(1'b0);

        for (int i = 0; i < 25; i++) begin
            bmode = int'($urandom_range(0, 2));
            send($urandom);
            wait_done(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
